// File: rtl/udma_l2_pkg.sv
// Shared types for the uDMA L2 port merger: request origin tag and the
// request payload bundle steered from the selected channel to memory.
package udma_l2_pkg;

    localparam int L2_ADDR_WIDTH = 32;
    localparam int L2_DATA_WIDTH = 32;
    localparam int L2_BE_WIDTH   = L2_DATA_WIDTH / 8;

    // Which uDMA channel issued a request; also the FIFO entry type.
    typedef enum logic {
        ORIG_RO = 1'b0,
        ORIG_WO = 1'b1
    } origin_e;

    // Request payload presented on the merged port alongside req.
    typedef struct packed {
        logic                     wen;
        logic [L2_ADDR_WIDTH-1:0] addr;
        logic [L2_BE_WIDTH-1:0]   be;
        logic [L2_DATA_WIDTH-1:0] wdata;
    } l2_req_t;

    // The channel that did not win an arbitration round.
    function automatic origin_e other_origin(input origin_e o);
        return (o == ORIG_RO) ? ORIG_WO : ORIG_RO;
    endfunction

endpackage

// File: rtl/udma_l2_origin_fifo.sv
// In-order record of which channel owns each outstanding memory request.
// One bit per entry; head is read out of the storage via the registered
// read pointer so response steering never depends on the current push.
module udma_l2_origin_fifo
    import udma_l2_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  origin_e        push_origin,
    input  logic           pop,
    output origin_e        head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    logic [DEPTH-1:0] slot_reg;
    logic [DEPTH-1:0] slot_we;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;

    // One write strobe per slot, decoded from the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Occupancy: push and pop together leave it unchanged.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                slot_reg[i] <= push_origin;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign head  = origin_e'(slot_reg[rd_ptr_reg]);
    assign count = count_reg;
    assign full  = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/udma_l2_port_mux.sv
// Merges the uDMA read-only and write-only L2 master ports onto one
// TCDM-style master. Round-robin arbitration with a stall lock, in-order
// response routing via an origin FIFO, and a sticky orphan-response flag.
module udma_l2_port_mux
    import udma_l2_pkg::*;
#(
    parameter int ADDR_WIDTH      = L2_ADDR_WIDTH,
    parameter int DATA_WIDTH      = L2_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_resetn_i,

    input  logic                    ro_req_i,
    output logic                    ro_gnt_o,
    input  logic                    ro_wen_i,
    input  logic [ADDR_WIDTH-1:0]   ro_addr_i,
    input  logic [DATA_WIDTH/8-1:0] ro_be_i,
    input  logic [DATA_WIDTH-1:0]   ro_wdata_i,
    output logic                    ro_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ro_rdata_o,

    input  logic                    wo_req_i,
    output logic                    wo_gnt_o,
    input  logic                    wo_wen_i,
    input  logic [ADDR_WIDTH-1:0]   wo_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wo_be_i,
    input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
    output logic                    wo_rvalid_o,
    output logic [DATA_WIDTH-1:0]   wo_rdata_o,

    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_wen_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    l2_req_t    req_ro;
    l2_req_t    req_wo;
    l2_req_t    req_sel;
    origin_e    sel;
    origin_e    prio_reg;
    origin_e    prio_next;
    origin_e    lock_sel_reg;
    origin_e    lock_sel_next;
    logic       lock_reg;
    logic       lock_next;
    logic       lock_req;
    logic       both_req;
    logic       accept;
    logic       pop;
    logic       err_reg;
    origin_e    fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic       has_outstanding;

    assign req_ro = '{wen: ro_wen_i, addr: ro_addr_i, be: ro_be_i, wdata: ro_wdata_i};
    assign req_wo = '{wen: wo_wen_i, addr: wo_addr_i, be: wo_be_i, wdata: wo_wdata_i};

    assign both_req = ro_req_i && wo_req_i;
    assign lock_req = (lock_sel_reg == ORIG_RO) ? ro_req_i : wo_req_i;

    // Channel selection: reset pins ro, a live lock wins, then prio on
    // contention, otherwise whichever single channel is requesting.
    always_comb begin
        sel = ORIG_RO;
        if (!sys_resetn_i) begin
            sel = ORIG_RO;
        end else if (lock_reg && lock_req) begin
            sel = lock_sel_reg;
        end else if (both_req) begin
            sel = prio_reg;
        end else if (wo_req_i) begin
            sel = ORIG_WO;
        end
    end

    assign req_sel   = (sel == ORIG_WO) ? req_wo : req_ro;
    assign mem_wen_o   = req_sel.wen;
    assign mem_addr_o  = req_sel.addr;
    assign mem_be_o    = req_sel.be;
    assign mem_wdata_o = req_sel.wdata;

    // A full FIFO holds the request low; the gate uses registered count so
    // a same-cycle pop only frees a slot from the next cycle on.
    assign mem_req_o = (ro_req_i || wo_req_i) && !fifo_full && sys_resetn_i;
    assign accept    = mem_req_o && mem_gnt_i;
    assign ro_gnt_o  = accept && (sel == ORIG_RO);
    assign wo_gnt_o  = accept && (sel == ORIG_WO);

    // Lock holds an ungranted selection stable; prio flips to the loser
    // after a contended grant.
    always_comb begin
        lock_next     = 1'b0;
        lock_sel_next = lock_sel_reg;
        prio_next     = prio_reg;
        if (mem_req_o && !mem_gnt_i) begin
            lock_next     = 1'b1;
            lock_sel_next = sel;
        end
        if (accept && both_req) begin
            prio_next = other_origin(sel);
        end
    end

    // Arbitration state registers.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_resetn_i) begin
            lock_reg     <= 1'b0;
            lock_sel_reg <= ORIG_RO;
            prio_reg     <= ORIG_RO;
        end else begin
            lock_reg     <= lock_next;
            lock_sel_reg <= lock_sel_next;
            prio_reg     <= prio_next;
        end
    end

    udma_l2_origin_fifo #(
        .DEPTH       (MAX_OUTSTANDING)
    ) u_origin_fifo (
        .clk         (sys_clk_i),
        .rst_n       (sys_resetn_i),
        .push        (accept),
        .push_origin (sel),
        .pop         (pop),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    // Orphan responses (nothing outstanding) are dropped without a pop.
    assign has_outstanding = (fifo_count != '0);
    assign pop = mem_rvalid_i && has_outstanding && sys_resetn_i;

    assign ro_rvalid_o = pop && (fifo_head == ORIG_RO);
    assign wo_rvalid_o = pop && (fifo_head == ORIG_WO);
    assign ro_rdata_o  = mem_rdata_i;
    assign wo_rdata_o  = mem_rdata_i;

    // Sticky error: any response arriving with an empty FIFO.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_resetn_i) begin
            err_reg <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;

endmodule
